// File: rtl/axi3_rd_responder_pkg.sv
// Shared types, AXI3 encodings and address-step helpers for the AXI3 read responder.
package axi3_rd_responder_pkg;

    typedef enum logic {
        RSP_IDLE,
        RSP_BURST
    } rsp_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Latched AR request (the ID is carried separately because its width is a parameter).
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_req_t;

    // Per-beat sideband travelling next to the data word through the skid buffer.
    typedef struct packed {
        logic [1:0] resp;
        logic       last;
    } r_tag_t;

    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

    // Address of the beat following req.addr within the burst described by req.
    function automatic logic [31:0] next_beat_addr(input ar_req_t req);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << req.size;
        mask = ((32'(req.len) + 32'd1) << req.size) - 32'd1;
        case (req.burst)
            BURST_FIXED: return req.addr;
            BURST_WRAP:  return (req.addr & ~mask) | ((req.addr + step) & mask);
            default:     return req.addr + step;
        endcase
    endfunction

endpackage

// File: rtl/axi3_rd_responder_skid.sv
// Two-entry fall-through skid buffer: an arriving beat is visible the same cycle and is
// parked only if the consumer does not take it, so outputs stay stable while stalled.
module axi_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             pop,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             stored;
    logic             store;
    logic             pop_stored;

    always_comb begin
        stored     = (count_q != 2'd0);
        out_valid  = stored | in_valid;
        out_data   = stored ? mem_q[rd_ptr_q] : in_data;
        pop        = out_valid & out_ready;
        // A beat bypasses storage only when the buffer is empty and the consumer takes it now.
        store      = in_valid & ~(~stored & out_ready);
        pop_stored = pop & stored;
        wr_ptr_d   = wr_ptr_q ^ store;
        rd_ptr_d   = rd_ptr_q ^ pop_stored;
        count_d    = count_q + {1'b0, store} - {1'b0, pop_stored};
    end

    assign count = count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage entries carry no reset; count_q alone decides whether they hold anything.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/axi3_rd_responder.sv
// AXI3 read-channel slave returning bursts from a synchronous 1-cycle-latency word RAM,
// one beat per cycle while rready is held, with SLVERR beats for illegal or unmapped requests.
module axi3_rd_responder
    import axi3_rd_responder_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] MEM_BASE   = 32'h1fc0_0000,
    parameter int          MEM_DEPTH  = 4096,
    parameter int          ID_WIDTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_WIDTH-1:0]          arid,
    input  logic [31:0]                  araddr,
    input  logic [3:0]                   arlen,
    input  logic [2:0]                   arsize,
    input  logic [1:0]                   arburst,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [ID_WIDTH-1:0]          rid,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic                         rvalid,
    input  logic                         rready,
    output logic                         ram_en,
    output logic [$clog2(MEM_DEPTH)-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0]        ram_rdata,
    output logic                         busy
);

    localparam int          BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int          SIZE_MAX       = $clog2(BYTES_PER_WORD);
    localparam int          RAM_AW         = $clog2(MEM_DEPTH);
    localparam logic [31:0] MEM_BYTES      = 32'(MEM_DEPTH * BYTES_PER_WORD);
    localparam int          PAYLOAD_W      = DATA_WIDTH + $bits(r_tag_t);

    rsp_state_t          state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    ar_req_t             req_q, req_d;
    logic [4:0]          issue_cnt_q, issue_cnt_d;
    logic [4:0]          beat_cnt_q, beat_cnt_d;
    logic                inflight_q, inflight_d;
    logic                err_q, err_d;
    logic                last_q, last_d;
    logic                addr_err_q, addr_err_d;

    logic [31:0]           offset;
    logic                  burst_err;
    logic                  addr_oob;
    logic                  beat_err;
    logic [2:0]            pending;
    logic                  can_issue;
    logic                  fifo_pop;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH-1:0] in_word;
    r_tag_t                in_tag;
    r_tag_t                out_tag;
    logic [PAYLOAD_W-1:0]  fifo_in;
    logic [PAYLOAD_W-1:0]  fifo_out;

    always_comb begin
        offset    = req_q.addr - MEM_BASE;
        burst_err = (req_q.burst == BURST_RSVD) || (req_q.size > 3'(SIZE_MAX))
                 || ((req_q.burst == BURST_WRAP) && !wrap_len_ok(req_q.len));
        addr_oob  = (offset >= MEM_BYTES);
        // Once a burst has touched unmapped space, every remaining beat of it is an error.
        beat_err  = burst_err | addr_oob | addr_err_q;
        // Beats already committed to the R path, credited with the one leaving this cycle.
        pending   = {1'b0, fifo_count} + {2'b00, inflight_q};
        can_issue = (state_q == RSP_BURST)
                 && (issue_cnt_q <= {1'b0, req_q.len})
                 && (pending < (3'd2 + {2'b00, fifo_pop}));
    end

    assign ram_en   = can_issue & ~beat_err;
    assign ram_addr = offset[SIZE_MAX +: RAM_AW];
    assign arready  = (state_q == RSP_IDLE);
    assign busy     = (state_q != RSP_IDLE);
    assign rid      = id_q;

    // RAM-return tagging: the flags issued alongside a read apply to the word arriving a cycle later.
    always_comb begin
        in_word     = '0;
        in_tag      = '0;
        if (inflight_q) begin
            in_word     = err_q ? '0 : ram_rdata;
            in_tag.resp = err_q ? RESP_SLVERR : RESP_OKAY;
            in_tag.last = last_q;
        end
        fifo_in = {in_word, in_tag};
    end

    axi_skid_fifo #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inflight_q),
        .in_data  (fifo_in),
        .out_valid(rvalid),
        .out_data (fifo_out),
        .out_ready(rready),
        .pop      (fifo_pop),
        .count    (fifo_count)
    );

    assign {rdata, out_tag} = fifo_out;
    assign rresp            = out_tag.resp;
    assign rlast            = out_tag.last;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        req_d       = req_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        addr_err_d  = addr_err_q;
        inflight_d  = can_issue;
        err_d       = beat_err;
        last_d      = (issue_cnt_q == {1'b0, req_q.len});

        case (state_q)
            RSP_IDLE: begin
                if (arvalid) begin
                    id_d        = arid;
                    req_d.addr  = araddr;
                    req_d.len   = arlen;
                    req_d.size  = arsize;
                    req_d.burst = arburst;
                    issue_cnt_d = 5'd0;
                    beat_cnt_d  = 5'd0;
                    addr_err_d  = 1'b0;
                    state_d     = RSP_BURST;
                end
            end
            RSP_BURST: begin
                if (can_issue) begin
                    issue_cnt_d = issue_cnt_q + 5'd1;
                    req_d.addr  = next_beat_addr(req_q);
                    addr_err_d  = addr_err_q | addr_oob;
                end
                if (fifo_pop) begin
                    beat_cnt_d = beat_cnt_q + 5'd1;
                    if (beat_cnt_q == {1'b0, req_q.len}) begin
                        state_d = RSP_IDLE;
                    end
                end
            end
            default: state_d = RSP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RSP_IDLE;
            id_q        <= '0;
            req_q       <= '0;
            issue_cnt_q <= 5'd0;
            beat_cnt_q  <= 5'd0;
            inflight_q  <= 1'b0;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            req_q       <= req_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
            last_q      <= last_d;
            addr_err_q  <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_axi3_rd_responder.sv
// Randomised self-checking bench for axi3_rd_responder against a burst-level reference model.
module tb_axi3_rd_responder;

    localparam logic [31:0] MEM_BASE  = 32'h1fc0_0000;
    localparam int          MEM_DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        ram_en;
    logic [11:0] ram_addr;
    logic [31:0] ram_rdata = '0;
    logic        busy;

    logic [31:0] mem [MEM_DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_data [$];
    logic [1:0]  exp_resp [$];
    logic        exp_last [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_addr];
    end

    axi3_rd_responder dut (
        .clk      (clk),
        .rst      (rst),
        .arid     (arid),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .arvalid  (arvalid),
        .arready  (arready),
        .rid      (rid),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready),
        .ram_en   (ram_en),
        .ram_addr (ram_addr),
        .ram_rdata(ram_rdata),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected beats from the AXI3 burst rules: byte address per beat, then map or error.
    task automatic build_expected(input logic [31:0] addr, input logic [3:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
        longint step, wrap_bytes, base, a, start;
        int     nbeats;
        bit     burst_bad, oob_seen;
        exp_data.delete();
        exp_resp.delete();
        exp_last.delete();
        start      = longint'(addr);
        nbeats     = int'(len) + 1;
        step       = longint'(1) << size;
        wrap_bytes = nbeats * step;
        base       = (start / wrap_bytes) * wrap_bytes;
        burst_bad  = (burst == 2'd3) || (size > 3'd2) ||
                     (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        oob_seen   = 1'b0;
        for (int n = 0; n < nbeats; n++) begin
            case (burst)
                2'd0:    a = start;
                2'd2:    a = base + ((start - base) + n * step) % wrap_bytes;
                default: a = start + n * step;
            endcase
            if (a < longint'(MEM_BASE) || a >= longint'(MEM_BASE) + MEM_DEPTH * 4) oob_seen = 1'b1;
            if (burst_bad || oob_seen) begin
                exp_data.push_back(32'd0);
                exp_resp.push_back(2'b10);
            end else begin
                exp_data.push_back(mem[(a - longint'(MEM_BASE)) / 4]);
                exp_resp.push_back(2'b00);
            end
            exp_last.push_back(n == nbeats - 1);
        end
    endtask

    // mode 0: rready held 1; mode 1: rready 1,0,0 repeating; mode 2: random rready.
    // abort_after >= 0 stops right after that many beats have been accepted.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int mode, input int abort_after);
        int   cyc, n, issued, max_ahead;
        bit   seen, held, any_ram_en, all_err;
        logic [31:0] h_data;
        logic [1:0]  h_resp;
        logic        h_last;
        build_expected(addr, len, size, burst);
        all_err = 1'b1;
        foreach (exp_resp[i]) if (exp_resp[i] != 2'b10) all_err = 1'b0;

        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        rready  = 1'b0;
        #1;
        check("arready_idle", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        check("busy_in_burst", {busy, arready}, 2'b10);
        cyc = 1; n = 0; issued = 0; max_ahead = 0;
        seen = 0; held = 0; any_ram_en = 0;
        while (n <= int'(len) && cyc < 300) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = ((cyc - 1) % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (ram_en) begin
                issued++;
                any_ram_en = 1'b1;
            end
            if (held) check("stall_hold", {rvalid, rdata, rresp, rlast}, {1'b1, h_data, h_resp, h_last});
            held = 1'b0;
            if (rvalid) begin
                if (!seen) check("first_rvalid_cycle", cyc, 2);
                seen = 1'b1;
                if (rready) begin
                    check("rdata", rdata, exp_data[n]);
                    check("rresp", rresp, exp_resp[n]);
                    check("rlast", rlast, exp_last[n]);
                    check("rid", rid, id);
                    n++;
                end else begin
                    held = 1'b1;
                    h_data = rdata; h_resp = rresp; h_last = rlast;
                end
            end
            if (issued - n > max_ahead) max_ahead = issued - n;
            if (abort_after >= 0 && n == abort_after) break;
            @(negedge clk);
            cyc++;
        end
        if (abort_after < 0) begin
            check("beats_returned", n, int'(len) + 1);
            #1;
            check("idle_after_burst", {busy, arready}, 2'b01);
            check("ram_run_ahead_le2", (max_ahead <= 2), 1'b1);
            if (all_err) check("no_ram_en_on_error", any_ram_en, 1'b0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  r_len;
        logic [2:0]  r_size;
        logic [1:0]  r_burst;
        logic [31:0] r_addr;
        int          sel;

        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = i;
        rst = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {arready, rvalid, rlast, rresp, rid, rdata, ram_en, busy},
              {1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 32'h0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        // Directed bursts.
        run_burst(4'h3, MEM_BASE,         4'd7, 3'd2, 2'b01, 0, -1);
        run_burst(4'h5, MEM_BASE,         4'd7, 3'd2, 2'b01, 1, -1);
        run_burst(4'h6, MEM_BASE + 32'h8, 4'd3, 3'd2, 2'b10, 0, -1);
        run_burst(4'h7, MEM_BASE + 32'h10, 4'd3, 3'd2, 2'b00, 0, -1);
        run_burst(4'h8, MEM_BASE - 32'd4, 4'd3, 3'd2, 2'b01, 0, -1);
        run_burst(4'h2, MEM_BASE,         4'd3, 3'd2, 2'b11, 0, -1);
        run_burst(4'h1, MEM_BASE + 32'h3ff8, 4'd3, 3'd2, 2'b01, 1, -1);

        // Reset in the middle of a burst.
        run_burst(4'h9, MEM_BASE, 4'd7, 3'd2, 2'b01, 0, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", {rvalid, arready, busy, ram_en}, 4'b0100);
        @(negedge clk);
        rst = 1'b0;
        run_burst(4'hc, MEM_BASE + 32'h40, 4'd1, 3'd2, 2'b01, 0, -1);

        // Randomised bursts, mostly legal, with occasional illegal sizes/lengths/types and edge addresses.
        for (int t = 0; t < 40; t++) begin
            r_len   = 4'($urandom_range(0, 15));
            sel     = $urandom_range(0, 9);
            r_size  = (sel == 0) ? 3'd3 : (sel < 3) ? 3'($urandom_range(0, 1)) : 3'd2;
            sel     = $urandom_range(0, 9);
            r_burst = (sel == 0) ? 2'b11 : (sel < 3) ? 2'b00 : (sel < 6) ? 2'b10 : 2'b01;
            if (r_burst == 2'b10 && $urandom_range(0, 3) != 0) begin
                sel   = $urandom_range(0, 3);
                r_len = (sel == 0) ? 4'd1 : (sel == 1) ? 4'd3 : (sel == 2) ? 4'd7 : 4'd15;
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      r_addr = MEM_BASE + 32'h4000 - 32'd4 * 32'($urandom_range(1, 6));
            else if (sel == 1) r_addr = MEM_BASE - 32'd4 * 32'($urandom_range(1, 3));
            else               r_addr = MEM_BASE + 32'd4 * 32'($urandom_range(0, MEM_DEPTH - 1));
            if (r_size < 3'd2) r_addr = r_addr + (32'($urandom_range(0, 3)) & ~((32'd1 << r_size) - 32'd1));
            run_burst(4'($urandom_range(0, 15)), r_addr, r_len, r_size, r_burst, 2, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
